// File: rtl/pip_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional perf counters (stall_cnt, flush_cnt) are built when PIP_STAGE_PERF_EN is defined.
module pip_stage_skid #(
   parameter int DATA_W     = 32,
   parameter int CTRL_W     = 16,
   parameter bit CLEAR_DATA = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIP_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_param_check
      $error("pip_stage_skid: DATA_W, CTRL_W and CNT_W must all be at least 1");
   end

   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;
   logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
   logic              s_valid_q, s_valid_d;
   logic [DATA_W-1:0] s_data_q,  s_data_d;
   logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
   logic              in_fire;
   logic              head_free;

   // Only flush makes in_ready combinational; otherwise it follows the skid register.
   assign in_ready  = !s_valid_q && !flush;
   assign in_fire   = in_valid && in_ready;
   assign head_free = !m_valid_q || out_ready;

   assign out_valid = m_valid_q;
   assign out_data  = m_data_q;
   assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_ctrl_d  = m_ctrl_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      s_ctrl_d  = s_ctrl_q;
      if (flush) begin
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
         m_ctrl_d  = '0;
         s_ctrl_d  = '0;
         if (CLEAR_DATA) begin
            m_data_d = '0;
            s_data_d = '0;
         end
      end else if (head_free) begin
         // Skid always drains before new input so FIFO order is kept.
         if (s_valid_q) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
            m_ctrl_d  = s_ctrl_q;
            s_valid_d = 1'b0;
         end else if (in_fire) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
            m_ctrl_d  = in_ctrl;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         s_valid_d = 1'b1;
         s_data_d  = in_data;
         s_ctrl_d  = in_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_ctrl_q  <= '0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_ctrl_q  <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_ctrl_q  <= m_ctrl_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_ctrl_q  <= s_ctrl_d;
      end
   end

`ifdef PIP_STAGE_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Both counters saturate rather than wrap.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (m_valid_q && !out_ready && stall_cnt_q != CNT_MAX) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush && (m_valid_q || s_valid_q) && flush_cnt_q != CNT_MAX) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pip_stage_skid.sv
// Bench for pip_stage_skid: hand-derived vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_pip_stage_skid;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic        clk;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_data;
   logic [15:0] in_ctrl;
   logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic [31:0] a_out_data, b_out_data;
   logic [15:0] a_out_ctrl, b_out_ctrl;
`ifdef PIP_STAGE_PERF_EN
   logic [CNT_W-1:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

   pip_stage_skid #(.DATA_W(32), .CTRL_W(16), .CLEAR_DATA(1'b0), .CNT_W(CNT_W)) u_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_data(a_out_data), .out_ctrl(a_out_ctrl)
`ifdef PIP_STAGE_PERF_EN
      , .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
`endif
   );

   pip_stage_skid #(.DATA_W(32), .CTRL_W(16), .CLEAR_DATA(1'b1), .CNT_W(CNT_W)) u_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_data(b_out_data), .out_ctrl(b_out_ctrl)
`ifdef PIP_STAGE_PERF_EN
      , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference model: the stage is a FIFO of at most two entries.
   typedef struct {
      logic [31:0] data;
      logic [15:0] ctrl;
   } entry_t;

   entry_t      q[$];
   logic [31:0] stale_a, stale_b;
   int          stall_m, flush_m;
   bit          known = 0;

   logic        obs_ov, obs_ir;
   logic [31:0] obs_a_od, obs_b_od;
   logic [15:0] obs_oc;
   int          obs_stall, obs_fcnt;

   task automatic cyc(input logic r, input logic f, input logic iv, input logic ordy,
                      input logic [31:0] d, input logic [15:0] c);
      int  pre;
      bit  ir_m;
      rst = r; flush = f; in_valid = iv; out_ready = ordy; in_data = d; in_ctrl = c;
      @(negedge clk);
      pre  = q.size();
      ir_m = (pre < 2) && !f;
      obs_ov = a_out_valid; obs_ir = a_in_ready; obs_a_od = a_out_data;
      obs_b_od = b_out_data; obs_oc = a_out_ctrl;
      obs_stall = 0; obs_fcnt = 0;
`ifdef PIP_STAGE_PERF_EN
      obs_stall = int'(a_stall_cnt); obs_fcnt = int'(a_flush_cnt);
`endif
      if (known) begin
         chk("a_out_valid", a_out_valid, (pre > 0));
         chk("b_out_valid", b_out_valid, (pre > 0));
         chk("a_in_ready", a_in_ready, ir_m);
         chk("b_in_ready", b_in_ready, ir_m);
         chk("a_out_data", a_out_data, (pre > 0) ? q[0].data : stale_a);
         chk("b_out_data", b_out_data, (pre > 0) ? q[0].data : stale_b);
         chk("a_out_ctrl", a_out_ctrl, (pre > 0) ? q[0].ctrl : 16'h0);
         chk("b_out_ctrl", b_out_ctrl, (pre > 0) ? q[0].ctrl : 16'h0);
`ifdef PIP_STAGE_PERF_EN
         chk("a_stall_cnt", a_stall_cnt, stall_m);
         chk("a_flush_cnt", a_flush_cnt, flush_m);
         chk("b_stall_cnt", b_stall_cnt, stall_m);
         chk("b_flush_cnt", b_flush_cnt, flush_m);
`endif
      end
      @(posedge clk);
      if (r) begin
         q.delete();
         stale_a = 0; stale_b = 0; stall_m = 0; flush_m = 0;
         known = 1;
      end else begin
         if (pre > 0 && !ordy && stall_m < CNT_MAX) stall_m++;
         if (f && pre > 0 && flush_m < CNT_MAX) flush_m++;
         if (f) begin
            q.delete();
            stale_b = 0;
         end else begin
            if (pre > 0 && ordy) void'(q.pop_front());
            if (iv && ir_m) q.push_back('{data: d, ctrl: c});
         end
         if (q.size() > 0) begin
            stale_a = q[0].data;
            stale_b = q[0].data;
         end
      end
      #1;
   endtask

   typedef struct {
      logic        r, f, iv, ordy;
      logic [31:0] d;
      logic [15:0] c;
      logic        ev;
      logic [31:0] ed;
      logic [15:0] ec;
      logic        eir;
   } vec_t;

   vec_t tbl[24];

   initial begin
      rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = 0; in_ctrl = 0;
      //            r f iv or  data      ctrl       ev exp_data  exp_ctrl   ir
      tbl[0]  = '{0,0,1,1, 32'h11, 16'hC011, 0, 32'h00, 16'h0000, 1};
      tbl[1]  = '{0,0,1,1, 32'h12, 16'hC012, 1, 32'h11, 16'hC011, 1};
      tbl[2]  = '{0,0,1,1, 32'h13, 16'hC013, 1, 32'h12, 16'hC012, 1};
      tbl[3]  = '{0,0,1,1, 32'h14, 16'hC014, 1, 32'h13, 16'hC013, 1};
      tbl[4]  = '{0,0,1,1, 32'h15, 16'hC015, 1, 32'h14, 16'hC014, 1};
      tbl[5]  = '{0,0,0,1, 32'h00, 16'h0000, 1, 32'h15, 16'hC015, 1};
      tbl[6]  = '{0,0,0,1, 32'h00, 16'h0000, 0, 32'h15, 16'h0000, 1};
      tbl[7]  = '{0,0,1,1, 32'h21, 16'hC021, 0, 32'h15, 16'h0000, 1};
      tbl[8]  = '{0,0,1,0, 32'h22, 16'hC022, 1, 32'h21, 16'hC021, 1};
      tbl[9]  = '{0,0,1,0, 32'h23, 16'hC023, 1, 32'h21, 16'hC021, 0};
      tbl[10] = '{0,0,1,0, 32'h23, 16'hC023, 1, 32'h21, 16'hC021, 0};
      tbl[11] = '{0,0,1,1, 32'h23, 16'hC023, 1, 32'h21, 16'hC021, 0};
      tbl[12] = '{0,0,1,1, 32'h23, 16'hC023, 1, 32'h22, 16'hC022, 1};
      tbl[13] = '{0,0,0,1, 32'h00, 16'h0000, 1, 32'h23, 16'hC023, 1};
      tbl[14] = '{0,0,0,1, 32'h00, 16'h0000, 0, 32'h23, 16'h0000, 1};
      tbl[15] = '{0,0,1,0, 32'h0A, 16'hFFFF, 0, 32'h23, 16'h0000, 1};
      tbl[16] = '{0,0,1,0, 32'h0B, 16'hFFFF, 1, 32'h0A, 16'hFFFF, 1};
      tbl[17] = '{0,1,1,0, 32'h0C, 16'hFFFF, 1, 32'h0A, 16'hFFFF, 0};
      tbl[18] = '{0,0,0,1, 32'h00, 16'h0000, 0, 32'h0A, 16'h0000, 1};
      tbl[19] = '{0,0,0,1, 32'h00, 16'h0000, 0, 32'h0A, 16'h0000, 1};
      tbl[20] = '{0,0,1,0, 32'h31, 16'hC031, 0, 32'h0A, 16'h0000, 1};
      tbl[21] = '{0,0,1,0, 32'h32, 16'hC032, 1, 32'h31, 16'hC031, 1};
      tbl[22] = '{1,0,0,0, 32'h00, 16'h0000, 1, 32'h31, 16'hC031, 0};
      tbl[23] = '{0,0,0,1, 32'h00, 16'h0000, 0, 32'h00, 16'h0000, 1};

      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);

      for (int i = 0; i < 24; i++) begin
         cyc(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].ordy, tbl[i].d, tbl[i].c);
         chk($sformatf("vec%0d_valid", i), obs_ov, tbl[i].ev);
         chk($sformatf("vec%0d_data", i), obs_a_od, tbl[i].ed);
         chk($sformatf("vec%0d_ctrl", i), obs_oc, tbl[i].ec);
         chk($sformatf("vec%0d_in_ready", i), obs_ir, tbl[i].eir);
         $display("vec %0d: in_valid=%0b data=%0h out_ready=%0b -> out_valid=%0b out_data=%0h in_ready=%0b",
                  i, tbl[i].iv, tbl[i].d, tbl[i].ordy, obs_ov, obs_a_od, obs_ir);
      end

      // Flush payload handling: CLEAR_DATA=0 keeps the head payload, CLEAR_DATA=1 zeroes it.
      cyc(0, 0, 1, 0, 32'h0A, 16'hFFFF);
      cyc(0, 0, 1, 0, 32'h0B, 16'hFFFF);
      cyc(0, 1, 1, 0, 32'h0C, 16'hFFFF);
      cyc(0, 0, 0, 0, 32'h0, 16'h0);
      chk("flush_keep_data", obs_a_od, 32'h0A);
      chk("flush_clear_data", obs_b_od, 32'h0);
      chk("flush_valid", obs_ov, 1'b0);
      $display("flush seq: a_out_data=%0h b_out_data=%0h out_valid=%0b", obs_a_od, obs_b_od, obs_ov);

`ifdef PIP_STAGE_PERF_EN
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("flush_cnt_empty", obs_fcnt, 0);
      cyc(0, 0, 1, 0, 32'h55, 16'h1);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("stall_cnt_sat", obs_stall, 15);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      chk("flush_cnt_one", obs_fcnt, 1);
      $display("perf seq: stall_cnt=%0d flush_cnt=%0d", obs_stall, obs_fcnt);
`endif

      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
             $urandom, 16'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
